alu_issue_stage: RTL

- Producer side of the ALU interface. Accepts one decoded-register-read RISC-V instruction per cycle over a valid/ready handshake.
- Derives the ALU function select and operands from the instruction and drives them, registered, toward the execute stage.
- Sits between register-file read and the ALU.
- A 2-entry skid buffer decouples in_ready from out_ready, so a downstream stall never combinationally reaches the upstream stage.

---
 rtl/alu_issue_stage_pkg.sv | 43 ++++
 rtl/alu_issue_stage_skid.sv | 80 ++++++++
 rtl/alu_issue_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: function-select codes, RV32 opcodes and the f3 -> ALUSel map.
// Imported by the issue stage and by the ALU itself.
package alu_defs;

    localparam logic [3:0] ALUadd  = 4'd0;
    localparam logic [3:0] ALUsub  = 4'd1;
    localparam logic [3:0] ALUsll  = 4'd2;
    localparam logic [3:0] ALUslt  = 4'd3;
    localparam logic [3:0] ALUsltu = 4'd4;
    localparam logic [3:0] ALUxor  = 4'd5;
    localparam logic [3:0] ALUsrl  = 4'd6;
    localparam logic [3:0] ALUsar  = 4'd7;
    localparam logic [3:0] ALUor   = 4'd8;
    localparam logic [3:0] ALUand  = 4'd9;
    localparam logic [3:0] ALUnop  = 4'd15;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects sub (f3=000) or arithmetic shift (f3=101); ignored elsewhere.
    function automatic logic [3:0] f3_to_alusel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        sel = ALUnop;
        case (f3)
            3'b000:  sel = alt ? ALUsub : ALUadd;
            3'b001:  sel = ALUsll;
            3'b010:  sel = ALUslt;
            3'b011:  sel = ALUsltu;
            3'b100:  sel = ALUxor;
            3'b101:  sel = alt ? ALUsar : ALUsrl;
            3'b110:  sel = ALUor;
            3'b111:  sel = ALUand;
            default: sel = ALUnop;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_issue_stage_skid.sv
// Generic 2-entry valid/ready buffer: a main slot driving the outputs and a skid slot.
// in_ready is registered so downstream stalls never reach upstream combinationally.
module alu_skid_buffer #(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_MAIN  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != S_EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_MAIN;
                    main_d  = in_data;
                end
            end
            S_MAIN: begin
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = S_FULL;
                    skid_d  = in_data;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (drain) begin
                    state_d = S_MAIN;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        in_ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU select and operands,
// then registers them through a 2-entry skid buffer toward execute.
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alusel,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    if (SKID_DEPTH != 2) begin : g_depth_check
        $error("alu_issue_stage: SKID_DEPTH must be 2");
    end

    localparam int unsigned PW = 2 * XLEN + 11;
    localparam logic [PW-1:0] NOP_PAYLOAD = {{(2 * XLEN){1'b0}}, ALUnop, 7'b0};

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_u, shamt;
    logic            is_shift;
    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0]      dec_sel;
    logic            dec_ill, dec_wen;
    logic [PW-1:0]   in_payload, out_payload;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign shamt  = XLEN'(in_instr[24:20]);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_sel = ALUnop;
        dec_ill = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec_ill = 1'b0;
                    dec_a   = in_rs1_val;
                    dec_b   = in_rs2_val;
                    dec_sel = f3_to_alusel(f3, f7 == F7_ALT);
                end
            end
            OPC_OPIMM: begin
                // f7 only constrains shifts; for other f3 it is immediate bits.
                if (!is_shift || f7 == F7_BASE || (f3 == 3'b101 && f7 == F7_ALT)) begin
                    dec_ill = 1'b0;
                    dec_a   = in_rs1_val;
                    dec_b   = is_shift ? shamt : imm_i;
                    dec_sel = f3_to_alusel(f3, f3 == 3'b101 && f7 == F7_ALT);
                end
            end
            OPC_LUI: begin
                dec_ill = 1'b0;
                dec_b   = imm_u;
                dec_sel = ALUadd;
            end
            OPC_AUIPC: begin
                dec_ill = 1'b0;
                dec_a   = in_pc;
                dec_b   = imm_u;
                dec_sel = ALUadd;
            end
            default: ;
        endcase
        dec_wen = !dec_ill && (rd != 5'd0);
    end

    assign in_payload = {dec_a, dec_b, dec_sel, rd, dec_wen, dec_ill};

    alu_skid_buffer #(
        .WIDTH     (PW),
        .RESET_VAL (NOP_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_a, out_b, out_alusel, out_rd, out_wen, out_illegal} = out_payload;

endmodule
